fb_scanout: RTL
===============

Name: fb_scanout

Overview:
- Video scan-out engine on the read-only port of the framebuffer dual-port block RAM.
- Generates raster timing and issues word reads on the RAM read port, which has 1-cycle latency.
- Unpacks each word MSB-first into BPP-bit pixels.
- Drives sync, data-enable and pixel outputs to the palette/DAC stage.
- Runs entirely in the pixel clock domain; the CPU writes the RAM through the other port.

Parameters:
- DATA, 32, framebuffer word width; must be a multiple of BPP.
- ADDR, 15, framebuffer word-address width.
- BPP, 4, bits per pixel; PPW = DATA/BPP pixels per word.
- H_VISIBLE, 640, visible pixels per line; must be a multiple of PPW.
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync lengths in clocks.
- V_VISIBLE, 400, visible lines.
- V_FP / V_SYNC / V_BP, 12 / 2 / 35, vertical porch and sync lengths in lines.
- HS_POL / VS_POL, 0 / 1, active level of hsync / vsync.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous active-high reset.
- fb_base  in  ADDR  framebuffer start word address; sampled once per frame.
- mem_rd  out  1  read strobe to RAM read port.
- mem_addr  out  ADDR  word address to RAM read port.
- mem_dout  in  DATA  RAM read data, valid the cycle after mem_rd.
- pixel  out  BPP  pixel index; 0 when de=0.
- de  out  1  data enable.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- frame_start  out  1  one-cycle pulse, aligned with the first visible pixel of a frame.

Behaviour:
- Reset (asynchronous):
  - h_cnt, v_cnt, line and word addresses, shift register: 0.
  - mem_rd=0, mem_addr=0, pixel=0, de=0, frame_start=0.
  - hsync=!HS_POL, vsync=!VS_POL.
  - Reset mid-frame aborts the frame; the first frame after release starts at h_cnt=0, v_cnt=0.
- Counters:
  - h_cnt counts 0..H_TOTAL-1, where H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP; it wraps to 0 and increments v_cnt.
  - v_cnt counts 0..V_TOTAL-1, then wraps to 0.
- Regions:
  - Visible: h_cnt<H_VISIBLE and v_cnt<V_VISIBLE.
  - Hsync active: H_VISIBLE+H_FP <= h_cnt < H_VISIBLE+H_FP+H_SYNC.
  - Vsync uses the same rule on v_cnt.
- Base address: at h_cnt=0, v_cnt=0, fb_base is latched into the line address and word address. A fb_base change mid-frame has no effect until the next frame.
- Fetch:
  - Condition: visible and h_cnt mod PPW == 0.
  - Action: mem_rd=1 (combinational from counters) and mem_addr=word address; the word address then increments by 1 (ADDR-bit wrap).
  - mem_rd is 0 in all other cycles.
  - At the end of each visible line the line address advances by H_VISIBLE/PPW, and the word address reloads from it.
- Pipeline, 2-cycle latency from counters to outputs:
  - Cycle k+1: if a fetch occurred at cycle k, pixel <= mem_dout[DATA-1 -: BPP] and shift <= mem_dout<<BPP. Otherwise pixel <= shift[DATA-1 -: BPP] and shift <<= BPP.
  - pixel is forced to 0 when the delayed visible flag is 0.
  - de, hsync, vsync and frame_start are delayed 2 stages so they align exactly with pixel.
  - frame_start is asserted with the pixel generated at h_cnt=0, v_cnt=0.
- No back-pressure: RAM reads always complete in 1 cycle, so no handshake is needed.

Optional Feature:
- Macro: FB_PIXEL_DOUBLE_EN.
- Defined:
  - Each pixel is held 2 clocks and each source line is displayed on 2 consecutive output lines.
  - Fetch occurs when h_cnt mod (2*PPW) == 0.
  - Line stride becomes H_VISIBLE/(2*PPW), and the line address advances only after odd output lines; even lines re-read the same words.
  - Timing and sync are unchanged.
- Undefined: one pixel per clock and one source line per output line, as described above.

Test Plan:
- Common small config: DATA=32, BPP=4, H_VISIBLE=16, H_FP=2, H_SYNC=2, H_BP=2, V_VISIBLE=4, V_FP=1, V_SYNC=1, V_BP=1, fb_base=0x100. The RAM model returns address-dependent data.
- Sync timing: hsync active for exactly 2 clocks starting 2+2 clocks after the last de of each line (pixel 16 plus 2-cycle pipeline). Period is 22 clocks; vsync spans 22 clocks once per 154-clock frame.
- Fetch: mem_rd pulses at h_cnt 0 and 8 of each visible line. Addresses are 0x100,0x101 on line 0, 0x102,0x103 on line 1, through 0x107 on line 3, then 0x100 on the next frame.
- Unpack: word 0x0123_4567 at 0x100 yields pixels 0,1,2,3,4,5,6,7 on consecutive de cycles, with frame_start coincident with pixel 0. Pixel is 0 whenever de=0.
- Base latch: change fb_base to 0x200 mid-frame; remaining reads stay in 0x10x, and the next frame starts at 0x200.
- Reset mid-line: assert rst at line 2, h_cnt 5. All outputs go immediately to their reset values with no further mem_rd; after release, the first mem_rd is at 0x100.
- Doubling (FB_PIXEL_DOUBLE_EN): each pixel lasts 2 clocks and mem_rd fires only at h_cnt 0. Output lines 0 and 1 both read 0x100; lines 2 and 3 read 0x101.

Source files
------------

// File: rtl/fb_scanout_if.sv
// Purpose: bundles the framebuffer read port and the video output bus of fb_scanout.
// Latency: none (wires only).
// Backpressure: none; RAM reads always complete in one cycle.
// Signals:
//   fb_base      framebuffer start word address (sampled by the engine once per frame)
//   mem_rd       read strobe to the RAM read port
//   mem_addr     word address to the RAM read port
//   mem_dout     RAM read data, valid the cycle after mem_rd
//   pixel        pixel index, 0 outside the visible area
//   de           data enable
//   hsync/vsync  sync outputs
//   frame_start  one-cycle pulse with the first visible pixel of a frame
// Modports: master = scan-out engine, slave = RAM + video sink.
interface fb_scanout_if #(
   parameter int DATA = 32,
   parameter int ADDR = 15,
   parameter int BPP  = 4
);
   logic [ADDR-1:0] fb_base;
   logic            mem_rd;
   logic [ADDR-1:0] mem_addr;
   logic [DATA-1:0] mem_dout;
   logic [BPP-1:0]  pixel;
   logic            de;
   logic            hsync;
   logic            vsync;
   logic            frame_start;

   modport master (
      input  fb_base,
      input  mem_dout,
      output mem_rd,
      output mem_addr,
      output pixel,
      output de,
      output hsync,
      output vsync,
      output frame_start
   );

   modport slave (
      output fb_base,
      output mem_dout,
      input  mem_rd,
      input  mem_addr,
      input  pixel,
      input  de,
      input  hsync,
      input  vsync,
      input  frame_start
   );
endinterface

// File: rtl/fb_scanout.sv
// Purpose: raster timing + framebuffer word fetch + MSB-first pixel unpack for video scan-out.
// Latency: 2 clocks from raster counters to pixel/de/hsync/vsync/frame_start.
// Backpressure: none; the RAM read port answers every read in exactly one cycle.
// Ports:
//   clk, rst   pixel clock, asynchronous active-high reset
//   bus        fb_scanout_if.master: fb_base, mem_rd/mem_addr/mem_dout, pixel, de,
//              hsync, vsync, frame_start
// Build option: define FB_PIXEL_DOUBLE_EN to show each pixel for 2 clocks and each
//   source line on 2 output lines (raster timing is unchanged).
module fb_scanout #(
   parameter int DATA      = 32,
   parameter int ADDR      = 15,
   parameter int BPP       = 4,
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 400,
   parameter int V_FP      = 12,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 35,
   parameter bit HS_POL    = 1'b0,
   parameter bit VS_POL    = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   fb_scanout_if.master bus
);

   localparam int PPW     = DATA / BPP;
   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

`ifdef FB_PIXEL_DOUBLE_EN
   // One word now covers 2*PPW clocks because every pixel is shown twice.
   localparam int FETCH_DIV = 2 * PPW;
`else
   localparam int FETCH_DIV = PPW;
`endif

   // Words per source line.
   localparam logic [ADDR-1:0] STRIDE = ADDR'(H_VISIBLE / FETCH_DIV);

   localparam logic [HW-1:0] H_VIS_C  = HW'(H_VISIBLE);
   localparam logic [HW-1:0] H_LAST_V = HW'(H_VISIBLE - 1);
   localparam logic [HW-1:0] H_END    = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] HS_BEG   = HW'(H_VISIBLE + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_DIV    = HW'(FETCH_DIV);

   localparam logic [VW-1:0] V_VIS_C  = VW'(V_VISIBLE);
   localparam logic [VW-1:0] V_END    = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] VS_BEG   = VW'(V_VISIBLE + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FP + V_SYNC);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [HW-1:0]   h_cnt_q, h_cnt_d;
   logic [VW-1:0]   v_cnt_q, v_cnt_d;
   logic [ADDR-1:0] line_addr_q, line_addr_d;
   logic [ADDR-1:0] word_addr_q, word_addr_d;

   // Stage 1: raster decode delayed one clock, lines up with mem_dout.
   logic            fetch_s1_q, fetch_s1_d;
   logic            vis_s1_q,   vis_s1_d;
   logic            hs_s1_q,    hs_s1_d;
   logic            vs_s1_q,    vs_s1_d;
   logic            fs_s1_q,    fs_s1_d;
`ifdef FB_PIXEL_DOUBLE_EN
   logic            odd_s1_q,   odd_s1_d;
`endif

   // Stage 2: registered video outputs.
   logic [DATA-1:0] shift_q, shift_d;
   logic [BPP-1:0]  pixel_q, pixel_d;
   logic            de_q,     de_d;
   logic            hsync_q,  hsync_d;
   logic            vsync_q,  vsync_d;
   logic            fs_q,     fs_d;

   // ------------------------------------------------------------------
   // Raster decode (combinational from the counters)
   // ------------------------------------------------------------------
   logic            visible;
   logic            frame_top;
   logic            fetch;
   logic            line_end;
   logic            hs_raw;
   logic            vs_raw;
   logic [ADDR-1:0] rd_addr;

   always_comb begin
      visible   = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
      frame_top = (h_cnt_q == '0) && (v_cnt_q == '0);
      fetch     = visible && ((h_cnt_q % H_DIV) == '0);
      line_end  = (h_cnt_q == H_LAST_V) && (v_cnt_q < V_VIS_C);
      hs_raw    = ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
      vs_raw    = ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
      // The first fetch of a frame happens in the same cycle fb_base is
      // latched, so it takes fb_base directly instead of the stale register.
      rd_addr   = frame_top ? bus.fb_base : word_addr_q;
   end

   // The counters sit at 0 (a fetch position) while reset is held; gating
   // keeps the RAM port quiet until reset is released.
   assign bus.mem_rd   = fetch && !rst;
   assign bus.mem_addr = (fetch && !rst) ? rd_addr : '0;

   // ------------------------------------------------------------------
   // Counters
   // ------------------------------------------------------------------
   always_comb begin
      h_cnt_d = h_cnt_q + HW'(1);
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_END) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_END) ? '0 : v_cnt_q + VW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Line / word address generation
   // ------------------------------------------------------------------
   always_comb begin
      line_addr_d = line_addr_q;
      word_addr_d = word_addr_q;

      if (frame_top) begin
         line_addr_d = bus.fb_base;
         word_addr_d = bus.fb_base;
      end

      if (fetch) begin
         word_addr_d = rd_addr + ADDR'(1);
      end

      // Last visible pixel of a line: set up the start of the next line.
      // No fetch lands here unless PPW is 1, and then the reload must win.
      if (line_end) begin
`ifdef FB_PIXEL_DOUBLE_EN
         if (v_cnt_q[0]) begin
            line_addr_d = line_addr_q + STRIDE;
            word_addr_d = line_addr_q + STRIDE;
         end else begin
            // Even output line: the next line re-reads the same source words.
            word_addr_d = line_addr_q;
         end
`else
         line_addr_d = line_addr_q + STRIDE;
         word_addr_d = line_addr_q + STRIDE;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Pipeline
   // ------------------------------------------------------------------
   always_comb begin
      fetch_s1_d = fetch;
      vis_s1_d   = visible;
      hs_s1_d    = hs_raw;
      vs_s1_d    = vs_raw;
      fs_s1_d    = frame_top && visible;
`ifdef FB_PIXEL_DOUBLE_EN
      odd_s1_d   = h_cnt_q[0];
`endif

      de_d    = vis_s1_q;
      hsync_d = hs_s1_q;
      vsync_d = vs_s1_q;
      fs_d    = fs_s1_q;

      if (fetch_s1_q) begin
         // Fresh word: show its top pixel now, keep the rest for later.
         pixel_d = bus.mem_dout[DATA-1 -: BPP];
         shift_d = bus.mem_dout << BPP;
`ifdef FB_PIXEL_DOUBLE_EN
      end else if (odd_s1_q) begin
         // Second clock of a doubled pixel.
         pixel_d = pixel_q;
         shift_d = shift_q;
`endif
      end else begin
         pixel_d = shift_q[DATA-1 -: BPP];
         shift_d = shift_q << BPP;
      end

      if (!vis_s1_q) begin
         pixel_d = '0;
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         line_addr_q <= '0;
         word_addr_q <= '0;
         fetch_s1_q  <= 1'b0;
         vis_s1_q    <= 1'b0;
         hs_s1_q     <= ~HS_POL;
         vs_s1_q     <= ~VS_POL;
         fs_s1_q     <= 1'b0;
`ifdef FB_PIXEL_DOUBLE_EN
         odd_s1_q    <= 1'b0;
`endif
         shift_q     <= '0;
         pixel_q     <= '0;
         de_q        <= 1'b0;
         hsync_q     <= ~HS_POL;
         vsync_q     <= ~VS_POL;
         fs_q        <= 1'b0;
      end else begin
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         line_addr_q <= line_addr_d;
         word_addr_q <= word_addr_d;
         fetch_s1_q  <= fetch_s1_d;
         vis_s1_q    <= vis_s1_d;
         hs_s1_q     <= hs_s1_d;
         vs_s1_q     <= vs_s1_d;
         fs_s1_q     <= fs_s1_d;
`ifdef FB_PIXEL_DOUBLE_EN
         odd_s1_q    <= odd_s1_d;
`endif
         shift_q     <= shift_d;
         pixel_q     <= pixel_d;
         de_q        <= de_d;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         fs_q        <= fs_d;
      end
   end

   assign bus.pixel       = pixel_q;
   assign bus.de          = de_q;
   assign bus.hsync       = hsync_q;
   assign bus.vsync       = vsync_q;
   assign bus.frame_start = fs_q;

endmodule
